oldland_cache_mem_arbiter: RTL and testbench

- Shares the single external memory port between the data cache (requester 0) and the instruction cache (requester 1). Each cache issues word-by-word line fills, evictions and uncached accesses on its own port.
- The arbiter grants one requester at a time and holds the grant across a locked burst, so a line fill or eviction is never interleaved with the other cache.
- Round-robin fairness applies between unlocked transactions.
- Sits between the cache way controllers and the bus/SDRAM interface.

---
 rtl/oldland_arb_pkg.sv | 13 +
 rtl/oldland_rr_pick2.sv | 12 +
 rtl/oldland_cache_mem_arbiter.sv | 106 ++++++++++
 tb/tb_oldland_cache_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oldland_arb_pkg.sv
// oldland_arb_pkg: shared encodings for the cache/memory arbiter
package oldland_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_GRANT_D = 3'b010,
        ST_GRANT_I = 3'b100
    } arb_state_t;

    localparam logic REQ_D = 1'b0;
    localparam logic REQ_I = 1'b1;

endpackage

// File: rtl/oldland_rr_pick2.sv
// oldland_rr_pick2: two-way round-robin selector, favours the requester that was not served last
module oldland_rr_pick2 (
    input  logic [1:0] reqs,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    assign valid = |reqs;
    assign grant = &reqs ? ~last : reqs[1];

endmodule

// File: rtl/oldland_cache_mem_arbiter.sv
// oldland_cache_mem_arbiter: shares the memory port between the data cache (0)
// and instruction cache (1), holding the grant across locked bursts.
module oldland_cache_mem_arbiter
    import oldland_arb_pkg::*;
#(
    parameter int ADDR_BITS      = 30,
    parameter bit FIRST_PRIORITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_access,
    input  logic                 i_access,
    input  logic                 d_lock,
    input  logic                 i_lock,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [31:0]          d_wr_val,
    input  logic [31:0]          i_wr_val,
    input  logic                 d_wr_en,
    input  logic                 i_wr_en,
    input  logic [3:0]           d_bytesel,
    input  logic [3:0]           i_bytesel,
    output logic [31:0]          d_data,
    output logic [31:0]          i_data,
    output logic                 d_ack,
    output logic                 i_ack,
    output logic                 d_error,
    output logic                 i_error,
    output logic                 m_access,
    output logic [ADDR_BITS-1:0] m_addr,
    output logic [31:0]          m_wr_val,
    output logic                 m_wr_en,
    output logic [3:0]           m_bytesel,
    input  logic [31:0]          m_data,
    input  logic                 m_ack,
    input  logic                 m_error,
    output logic                 busy
);

    arb_state_t state, next_state;
    logic       last;
    logic       pick, pick_valid;
    logic       grant_d, grant_i;

    oldland_rr_pick2 u_pick (
        .reqs  ({i_access, d_access}),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            last  <= ~FIRST_PRIORITY;
        end else begin
            state <= next_state;
            last  <= next_state == ST_GRANT_D ? REQ_D :
                     next_state == ST_GRANT_I ? REQ_I : last;
        end
    end

    // An unlocked owner yields on an ack so back-to-back uncached accesses cannot starve the peer.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:
                if (pick_valid)
                    next_state = pick == REQ_I ? ST_GRANT_I : ST_GRANT_D;
            ST_GRANT_D:
                if (!d_lock) begin
                    if (!d_access)
                        next_state = i_access ? ST_GRANT_I : ST_IDLE;
                    else if (m_ack && i_access)
                        next_state = ST_GRANT_I;
                end
            ST_GRANT_I:
                if (!i_lock) begin
                    if (!i_access)
                        next_state = d_access ? ST_GRANT_D : ST_IDLE;
                    else if (m_ack && d_access)
                        next_state = ST_GRANT_D;
                end
            default:
                next_state = ST_IDLE;
        endcase
    end

    assign grant_d = state == ST_GRANT_D;
    assign grant_i = state == ST_GRANT_I;
    assign busy    = grant_d | grant_i;

    assign m_access  = grant_d ? d_access  : grant_i ? i_access  : 1'b0;
    assign m_addr    = grant_d ? d_addr    : grant_i ? i_addr    : '0;
    assign m_wr_val  = grant_d ? d_wr_val  : grant_i ? i_wr_val  : '0;
    assign m_wr_en   = grant_d ? d_wr_en   : grant_i ? i_wr_en   : 1'b0;
    assign m_bytesel = grant_d ? d_bytesel : grant_i ? i_bytesel : '0;

    assign d_ack   = grant_d & m_ack;
    assign i_ack   = grant_i & m_ack;
    assign d_error = grant_d & m_error;
    assign i_error = grant_i & m_error;
    assign d_data  = grant_d ? m_data : '0;
    assign i_data  = grant_i ? m_data : '0;

endmodule

// File: tb/tb_oldland_cache_mem_arbiter.sv
// tb_oldland_cache_mem_arbiter: directed and random stimulus against an ownership model
module tb_oldland_cache_mem_arbiter;

    logic        clk = 1'b0, rst = 1'b0;
    logic        d_access = 0, i_access = 0, d_lock = 0, i_lock = 0;
    logic [29:0] d_addr = '0, i_addr = '0;
    logic [31:0] d_wr_val = '0, i_wr_val = '0;
    logic        d_wr_en = 0, i_wr_en = 0;
    logic [3:0]  d_bytesel = '0, i_bytesel = '0;
    logic [31:0] d_data, i_data;
    logic        d_ack, i_ack, d_error, i_error;
    logic        m_access, m_wr_en, busy;
    logic [29:0] m_addr;
    logic [31:0] m_wr_val;
    logic [3:0]  m_bytesel;
    logic [31:0] m_data = '0;
    logic        m_ack = 0, m_error = 0;

    int total = 0, bad = 0;
    int owner = -1;
    int last_srv = 1;

    always #5 clk = ~clk;

    oldland_cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .d_access(d_access), .i_access(i_access), .d_lock(d_lock), .i_lock(i_lock),
        .d_addr(d_addr), .i_addr(i_addr), .d_wr_val(d_wr_val), .i_wr_val(i_wr_val),
        .d_wr_en(d_wr_en), .i_wr_en(i_wr_en), .d_bytesel(d_bytesel), .i_bytesel(i_bytesel),
        .d_data(d_data), .i_data(i_data), .d_ack(d_ack), .i_ack(i_ack),
        .d_error(d_error), .i_error(i_error),
        .m_access(m_access), .m_addr(m_addr), .m_wr_val(m_wr_val), .m_wr_en(m_wr_en),
        .m_bytesel(m_bytesel), .m_data(m_data), .m_ack(m_ack), .m_error(m_error),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic gd, gi;
        gd = owner == 0;
        gi = owner == 1;
        chk("m_access", {31'b0, m_access}, {31'b0, gd ? d_access : gi ? i_access : 1'b0});
        chk("m_addr", {2'b0, m_addr}, gd ? {2'b0, d_addr} : gi ? {2'b0, i_addr} : 32'h0);
        chk("m_wr_val", m_wr_val, gd ? d_wr_val : gi ? i_wr_val : 32'h0);
        chk("m_wr_en", {31'b0, m_wr_en}, {31'b0, gd ? d_wr_en : gi ? i_wr_en : 1'b0});
        chk("m_bytesel", {28'b0, m_bytesel}, {28'b0, gd ? d_bytesel : gi ? i_bytesel : 4'h0});
        chk("d_ack", {31'b0, d_ack}, {31'b0, gd & m_ack});
        chk("i_ack", {31'b0, i_ack}, {31'b0, gi & m_ack});
        chk("d_error", {31'b0, d_error}, {31'b0, gd & m_error});
        chk("i_error", {31'b0, i_error}, {31'b0, gi & m_error});
        chk("d_data", d_data, gd ? m_data : 32'h0);
        chk("i_data", i_data, gi ? m_data : 32'h0);
        chk("busy", {31'b0, busy}, {31'b0, owner >= 0});
    endtask

    // Ownership model: who holds the port after this edge, from the arbitration rules.
    task automatic upd();
        logic acc [2];
        logic lck [2];
        int o;
        acc[0] = d_access; acc[1] = i_access;
        lck[0] = d_lock;   lck[1] = i_lock;
        if (owner < 0) begin
            if (acc[0] && acc[1]) owner = 1 - last_srv;
            else if (acc[0]) owner = 0;
            else if (acc[1]) owner = 1;
        end else begin
            o = 1 - owner;
            if (lck[owner]) owner = owner;
            else if (!acc[owner]) owner = acc[o] ? o : -1;
            else if (m_ack && acc[o]) owner = o;
        end
        if (owner >= 0) last_srv = owner;
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic edge_();
        @(posedge clk);
        upd();
        #1;
    endtask

    task automatic tick();
        settle();
        edge_();
    endtask

    initial begin
        // reset with both caches already requesting
        d_access = 1; i_access = 1; d_addr = 30'h111; i_addr = 30'h222;
        d_wr_val = 32'h1111_0000; i_wr_val = 32'h2222_0000; d_bytesel = 4'hf; i_bytesel = 4'h3;
        repeat (2) @(posedge clk);
        settle();
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_m_access", {31'b0, m_access}, 32'h0);
        #1 rst = 1;
        edge_();
        settle();
        chk("first_prio_d", {2'b0, m_addr}, 32'h111);
        edge_();
        d_access = 0;
        tick();
        settle();
        chk("alt_then_i", {2'b0, m_addr}, 32'h222);
        edge_();
        i_access = 0;
        tick();
        d_access = 1; i_access = 1;
        tick();
        settle();
        chk("alt_back_d", {2'b0, m_addr}, 32'h111);
        edge_();
        d_access = 0; i_access = 0;
        tick();
        tick();

        // single uncached data read
        d_access = 1; d_addr = 30'h100;
        tick();
        settle();
        chk("read_m_access", {31'b0, m_access}, 32'h1);
        edge_();
        tick();
        m_ack = 1; m_data = 32'hDEADBEEF;
        settle();
        chk("read_d_ack", {31'b0, d_ack}, 32'h1);
        chk("read_d_data", d_data, 32'hDEADBEEF);
        chk("read_i_ack", {31'b0, i_ack}, 32'h0);
        edge_();
        d_access = 0; m_ack = 0;
        tick();
        settle();
        chk("read_idle", {31'b0, busy}, 32'h0);
        edge_();

        // locked 8-word instruction fill, data request arrives mid-burst
        i_access = 1; i_lock = 1; i_addr = 30'h400;
        tick();
        for (int w = 0; w < 8; w++) begin
            i_addr = 30'h400 + 30'(w);
            m_ack = 1; m_data = $urandom;
            if (w == 2) begin d_access = 1; d_addr = 30'h500; end
            settle();
            chk("fill_addr", {2'b0, m_addr}, 32'h400 + w);
            chk("fill_d_ack", {31'b0, d_ack}, 32'h0);
            edge_();
        end
        i_lock = 0; i_access = 0; m_ack = 0;
        tick();
        m_ack = 1;
        settle();
        chk("handover_addr", {2'b0, m_addr}, 32'h500);
        chk("handover_d_ack", {31'b0, d_ack}, 32'h1);
        edge_();
        d_access = 0; m_ack = 0;
        tick();
        tick();

        // back-to-back unlocked data accesses with instruction pending
        d_access = 1; d_addr = 30'h600;
        tick();
        i_access = 1; i_addr = 30'h700; m_ack = 1;
        settle();
        chk("b2b_d_ack", {31'b0, d_ack}, 32'h1);
        edge_();
        settle();
        chk("b2b_i_addr", {2'b0, m_addr}, 32'h700);
        chk("b2b_i_ack", {31'b0, i_ack}, 32'h1);
        chk("b2b_d_ack0", {31'b0, d_ack}, 32'h0);
        edge_();
        m_ack = 0;
        settle();
        chk("b2b_d_again", {2'b0, m_addr}, 32'h600);
        edge_();
        d_access = 0; i_access = 0;
        tick();
        tick();

        // bus error on a locked data transfer
        d_access = 1; d_lock = 1;
        tick();
        m_error = 1;
        settle();
        chk("err_d", {31'b0, d_error}, 32'h1);
        chk("err_i", {31'b0, i_error}, 32'h0);
        edge_();
        m_error = 0; d_lock = 0; d_access = 0;
        tick();
        settle();
        chk("err_release", {31'b0, busy}, 32'h0);
        edge_();

        // asynchronous reset in the middle of an instruction burst
        i_access = 1; i_lock = 1;
        tick();
        m_ack = 1;
        tick();
        @(negedge clk);
        #1 rst = 0;
        #1;
        chk("arst_m_access", {31'b0, m_access}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_i_ack", {31'b0, i_ack}, 32'h0);
        owner = -1; last_srv = 1;
        check_all();
        i_access = 0; i_lock = 0; m_ack = 0; d_access = 1; d_addr = 30'h800;
        #1 rst = 1;
        edge_();
        settle();
        chk("arst_regrant", {2'b0, m_addr}, 32'h800);
        edge_();
        d_access = 0;
        tick();
        tick();

        // random traffic
        repeat (600) begin
            d_access  = $urandom_range(0, 3) != 0;
            i_access  = $urandom_range(0, 3) != 0;
            d_lock    = $urandom_range(0, 3) == 0;
            i_lock    = $urandom_range(0, 3) == 0;
            d_addr    = 30'($urandom);
            i_addr    = 30'($urandom);
            d_wr_val  = $urandom;
            i_wr_val  = $urandom;
            d_wr_en   = 1'($urandom);
            i_wr_en   = 1'($urandom);
            d_bytesel = 4'($urandom);
            i_bytesel = 4'($urandom);
            m_data    = $urandom;
            m_ack     = 1'($urandom);
            m_error   = $urandom_range(0, 7) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
